// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_unit
// Purpose  : Machine-mode CSR unit. Implements mstatus, mie, mtvec, mscratch,
//            mepc, mcause, mip and the 64-bit mcycle/minstret counters, with
//            RW/RS/RC CSR operations, atomic trap-entry and mret updates of
//            mstatus, interrupt pending/cause generation and trap vectoring.
// Ports    :
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_csr_op/addr/src       CSR instruction (00 none, 01 RW, 10 RS, 11 RC)
//   o_csr_rdata             pre-write value of the addressed CSR (comb.)
//   o_csr_illegal           op != 00 on an unimplemented address
//   i_exc_valid/cause/pc    trap entry strobe, mcause value, faulting PC
//   i_mret, i_retire        mret retiring, one instruction retired
//   i_irq_timer, i_irq_ext  level interrupt lines
//   o_irq_pending/cause     enabled interrupt pending and its cause
//   o_trap_vec, o_mepc      trap target for i_exc_cause, saved PC for mret
// Revision : 1.0 - initial release
// ============================================================================
module csr_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
   parameter bit              HAS_COUNTERS = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [1:0]      i_csr_op,
   input  logic [11:0]     i_csr_addr,
   input  logic [XLEN-1:0] i_csr_src,
   output logic [XLEN-1:0] o_csr_rdata,
   output logic            o_csr_illegal,
   input  logic            i_exc_valid,
   input  logic [XLEN-1:0] i_exc_cause,
   input  logic [XLEN-1:0] i_exc_pc,
   input  logic            i_mret,
   input  logic            i_retire,
   input  logic            i_irq_timer,
   input  logic            i_irq_ext,
   output logic            o_irq_pending,
   output logic [XLEN-1:0] o_irq_cause,
   output logic [XLEN-1:0] o_trap_vec,
   output logic [XLEN-1:0] o_mepc
);

   localparam logic [11:0] c_addr_mstatus   = 12'h300;
   localparam logic [11:0] c_addr_mie       = 12'h304;
   localparam logic [11:0] c_addr_mtvec     = 12'h305;
   localparam logic [11:0] c_addr_mscratch  = 12'h340;
   localparam logic [11:0] c_addr_mepc      = 12'h341;
   localparam logic [11:0] c_addr_mcause    = 12'h342;
   localparam logic [11:0] c_addr_mip       = 12'h344;
   localparam logic [11:0] c_addr_mcycle    = 12'hB00;
   localparam logic [11:0] c_addr_minstret  = 12'hB02;
   localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
   localparam logic [11:0] c_addr_minstreth = 12'hB82;

   localparam logic [1:0] c_op_none = 2'b00;
   localparam logic [1:0] c_op_rw   = 2'b01;
   localparam logic [1:0] c_op_rs   = 2'b10;
   localparam logic [1:0] c_op_rc   = 2'b11;

   localparam logic [XLEN-1:0] c_cause_timer = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
   localparam logic [XLEN-1:0] c_cause_ext   = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

   // architectural state
   logic            r_mstatus_mie;
   logic            r_mstatus_mpie;
   logic            r_mie_mtie;
   logic            r_mie_meie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [63:0]     r_mcycle;
   logic [63:0]     r_minstret;

   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_mie;
   logic [XLEN-1:0] w_mip;
   logic [XLEN-1:0] w_mcycleh;
   logic [XLEN-1:0] w_minstreth;
   logic            w_hit;
   logic            w_wr;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_mtvec_wdata;
   logic [63:0]     w_cyc_inc;
   logic [63:0]     w_ins_inc;
   logic [63:0]     w_cyc_next;
   logic [63:0]     w_ins_next;
   logic [XLEN-1:0] w_tvec_base;
   logic            w_pend_timer;
   logic            w_pend_ext;

   // ------------------------------------------------------------------------
   // CSR views assembled from the stored bits
   // ------------------------------------------------------------------------
   always_comb begin
      w_mstatus        = '0;
      w_mstatus[12:11] = 2'b11;          // MPP: machine mode only
      w_mstatus[7]     = r_mstatus_mpie;
      w_mstatus[3]     = r_mstatus_mie;

      w_mie            = '0;
      w_mie[7]         = r_mie_mtie;
      w_mie[11]        = r_mie_meie;

      w_mip            = '0;
      w_mip[7]         = i_irq_timer;
      w_mip[11]        = i_irq_ext;
   end

   // ------------------------------------------------------------------------
   // Read mux and address decode
   // ------------------------------------------------------------------------
   always_comb begin
      o_csr_rdata = '0;
      w_hit       = 1'b1;
      case (i_csr_addr)
         c_addr_mstatus  : o_csr_rdata = w_mstatus;
         c_addr_mie      : o_csr_rdata = w_mie;
         c_addr_mtvec    : o_csr_rdata = r_mtvec;
         c_addr_mscratch : o_csr_rdata = r_mscratch;
         c_addr_mepc     : o_csr_rdata = r_mepc;
         c_addr_mcause   : o_csr_rdata = r_mcause;
         c_addr_mip      : o_csr_rdata = w_mip;
         c_addr_mcycle   : begin
            if (HAS_COUNTERS) o_csr_rdata = r_mcycle[XLEN-1:0];
            else              w_hit       = 1'b0;
         end
         c_addr_minstret : begin
            if (HAS_COUNTERS) o_csr_rdata = r_minstret[XLEN-1:0];
            else              w_hit       = 1'b0;
         end
         c_addr_mcycleh  : begin
            if (HAS_COUNTERS && XLEN == 32) o_csr_rdata = w_mcycleh;
            else                            w_hit       = 1'b0;
         end
         c_addr_minstreth: begin
            if (HAS_COUNTERS && XLEN == 32) o_csr_rdata = w_minstreth;
            else                            w_hit       = 1'b0;
         end
         default         : w_hit = 1'b0;
      endcase
   end

   assign o_csr_illegal = (i_csr_op != c_op_none) && !w_hit;
   assign w_wr          = (i_csr_op != c_op_none) &&  w_hit;

   // Read-modify-write value; RS/RC with a zero source still write back.
   always_comb begin
      case (i_csr_op)
         c_op_rw : w_wdata = i_csr_src;
         c_op_rs : w_wdata = o_csr_rdata | i_csr_src;
         c_op_rc : w_wdata = o_csr_rdata & ~i_csr_src;
         default : w_wdata = o_csr_rdata;
      endcase
   end

   // Reserved vector modes (1x) collapse to direct mode.
   assign w_mtvec_wdata = {w_wdata[XLEN-1:2], (w_wdata[1] ? 2'b00 : w_wdata[1:0])};

   // ------------------------------------------------------------------------
   // Non-counter state. Trap entry beats mret beats a CSR write for the
   // registers they share; other CSRs accept the write regardless.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie_mtie     <= 1'b0;
         r_mie_meie     <= 1'b0;
         r_mtvec        <= MTVEC_RESET;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
      end else begin
         if (i_exc_valid) begin
            r_mepc         <= {i_exc_pc[XLEN-1:2], 2'b00};
            r_mcause       <= i_exc_cause;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_wr) begin
            case (i_csr_addr)
               c_addr_mstatus: begin
                  r_mstatus_mie  <= w_wdata[3];
                  r_mstatus_mpie <= w_wdata[7];
               end
               c_addr_mepc   : r_mepc   <= {w_wdata[XLEN-1:2], 2'b00};
               c_addr_mcause : r_mcause <= w_wdata;
               default       : ;
            endcase
         end

         if (w_wr) begin
            case (i_csr_addr)
               c_addr_mie     : begin
                  r_mie_mtie <= w_wdata[7];
                  r_mie_meie <= w_wdata[11];
               end
               c_addr_mtvec   : r_mtvec    <= w_mtvec_wdata;
               c_addr_mscratch: r_mscratch <= w_wdata;
               default        : ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Counters: a CSR write replaces the increment for the half it targets;
   // the other half still takes its increment/carry.
   // ------------------------------------------------------------------------
   assign w_cyc_inc = r_mcycle + 64'd1;
   assign w_ins_inc = r_minstret + {63'd0, i_retire};

   if (XLEN == 32) begin : g_split_counters
      assign w_mcycleh   = r_mcycle[63:32];
      assign w_minstreth = r_minstret[63:32];

      always_comb begin
         w_cyc_next = w_cyc_inc;
         w_ins_next = w_ins_inc;
         if (w_wr) begin
            case (i_csr_addr)
               c_addr_mcycle   : w_cyc_next = {w_cyc_inc[63:32], w_wdata};
               c_addr_mcycleh  : w_cyc_next = {w_wdata, w_cyc_inc[31:0]};
               c_addr_minstret : w_ins_next = {w_ins_inc[63:32], w_wdata};
               c_addr_minstreth: w_ins_next = {w_wdata, w_ins_inc[31:0]};
               default         : ;
            endcase
         end
      end
   end else begin : g_full_counters
      assign w_mcycleh   = '0;
      assign w_minstreth = '0;

      always_comb begin
         w_cyc_next = w_cyc_inc;
         w_ins_next = w_ins_inc;
         if (w_wr) begin
            case (i_csr_addr)
               c_addr_mcycle  : w_cyc_next = 64'(w_wdata);
               c_addr_minstret: w_ins_next = 64'(w_wdata);
               default        : ;
            endcase
         end
      end
   end

   if (HAS_COUNTERS) begin : g_counters
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
         end else begin
            r_mcycle   <= w_cyc_next;
            r_minstret <= w_ins_next;
         end
      end
   end else begin : g_no_counters
      always_ff @(posedge i_clk) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end
   end

   // ------------------------------------------------------------------------
   // Trap vector and interrupt status
   // ------------------------------------------------------------------------
   assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
   assign o_trap_vec  = (r_mtvec[1:0] == 2'b01 && i_exc_cause[XLEN-1])
                      ? w_tvec_base + {i_exc_cause[XLEN-3:0], 2'b00}
                      : w_tvec_base;

   assign w_pend_timer  = i_irq_timer & r_mie_mtie;
   assign w_pend_ext    = i_irq_ext   & r_mie_meie;
   assign o_irq_pending = r_mstatus_mie & (w_pend_timer | w_pend_ext);
   assign o_irq_cause   = w_pend_ext ? c_cause_ext : c_cause_timer;

   assign o_mepc = r_mepc;

endmodule
`default_nettype wire
